// File: rtl/square_voice_allocator.sv
// Polyphony allocator for square-wave voices: retrigger, lowest free voice, else steal oldest.
// Define SQUARE_VOICE_STEAL_EN to build oldest-voice stealing; otherwise a full bank drops the note-on.
module square_voice_allocator #(
  parameter int NUM_VOICES = 4,
  parameter int KEY_W      = 7,
  parameter int AGE_W      = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     evt_valid,
  output logic                     evt_ready,
  input  logic                     evt_on,
  input  logic [KEY_W-1:0]         evt_key,
  input  logic [15:0]              evt_period,
  input  logic [15:0]              evt_duty,
  output logic [16*NUM_VOICES-1:0] voice_period,
  output logic [16*NUM_VOICES-1:0] voice_duty,
  output logic [NUM_VOICES-1:0]    voice_gate,
  output logic [NUM_VOICES-1:0]    voice_restart,
  output logic                     evt_dropped,
  output logic [4:0]               active_count
);

  localparam int IDX_W = $clog2(NUM_VOICES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SCAN  = 2'd1;
  localparam logic [1:0] APPLY = 2'd2;

  logic [1:0]       state;
  logic [IDX_W-1:0] scan_idx;

  logic             lat_on;
  logic [KEY_W-1:0] lat_key;
  logic [15:0]      lat_period;
  logic [15:0]      lat_duty;

  logic [15:0]           period_r [NUM_VOICES];
  logic [15:0]           duty_r   [NUM_VOICES];
  logic [KEY_W-1:0]      key_r    [NUM_VOICES];
  logic [NUM_VOICES-1:0] gate_r;

  logic             match_found;
  logic [IDX_W-1:0] match_idx;
  logic             free_found;
  logic [IDX_W-1:0] free_idx;

`ifdef SQUARE_VOICE_STEAL_EN
  logic [AGE_W-1:0] stamp_r [NUM_VOICES];
  logic [AGE_W-1:0] stamp_cnt;
  logic             old_found;
  logic [IDX_W-1:0] old_idx;
  logic [AGE_W-1:0] old_age;
  logic [AGE_W-1:0] scan_age;
`endif

  logic                  scan_gate;
  logic                  scan_hit;
  logic                  do_on;
  logic                  do_off;
  logic                  drop;
  logic [IDX_W-1:0]      tgt_idx;
  logic [15:0]           duty_clip;
  logic [NUM_VOICES-1:0] gate_nxt;
  logic [NUM_VOICES-1:0] restart_nxt;
  logic [4:0]            count_nxt;

  assign evt_ready = (state == IDLE) && !reset;

  assign scan_gate = gate_r[scan_idx];
  assign scan_hit  = scan_gate && (key_r[scan_idx] == lat_key);
`ifdef SQUARE_VOICE_STEAL_EN
  // Age is modular so a wrapped stamp counter still ranks voices correctly.
  assign scan_age  = stamp_cnt - stamp_r[scan_idx];
`endif

  assign duty_clip = (lat_duty > lat_period) ? lat_period : lat_duty;

  always_comb begin
    do_on   = 1'b0;
    do_off  = 1'b0;
    drop    = 1'b0;
    tgt_idx = '0;
    if (lat_on) begin
      if (lat_period == 16'd0) begin
        drop = 1'b1;
      end else if (match_found) begin
        do_on   = 1'b1;
        tgt_idx = match_idx;
      end else if (free_found) begin
        do_on   = 1'b1;
        tgt_idx = free_idx;
`ifdef SQUARE_VOICE_STEAL_EN
      end else if (old_found) begin
        do_on   = 1'b1;
        tgt_idx = old_idx;
`endif
      end else begin
        drop = 1'b1;
      end
    end else begin
      if (match_found) begin
        do_off  = 1'b1;
        tgt_idx = match_idx;
      end else begin
        drop = 1'b1;
      end
    end
  end

  always_comb begin
    gate_nxt    = gate_r;
    restart_nxt = '0;
    if (do_on) begin
      gate_nxt[tgt_idx]    = 1'b1;
      restart_nxt[tgt_idx] = 1'b1;
    end
    if (do_off) begin
      gate_nxt[tgt_idx] = 1'b0;
    end
    count_nxt = '0;
    for (int unsigned i = 0; i < NUM_VOICES; i++) begin
      count_nxt = count_nxt + 5'(gate_nxt[i]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      scan_idx      <= '0;
      lat_on        <= 1'b0;
      lat_key       <= '0;
      lat_period    <= '0;
      lat_duty      <= '0;
      gate_r        <= '0;
      match_found   <= 1'b0;
      match_idx     <= '0;
      free_found    <= 1'b0;
      free_idx      <= '0;
      voice_restart <= '0;
      evt_dropped   <= 1'b0;
      active_count  <= '0;
      for (int unsigned i = 0; i < NUM_VOICES; i++) begin
        period_r[i] <= '0;
        duty_r[i]   <= '0;
        key_r[i]    <= '0;
      end
`ifdef SQUARE_VOICE_STEAL_EN
      stamp_cnt <= '0;
      old_found <= 1'b0;
      old_idx   <= '0;
      old_age   <= '0;
      for (int unsigned i = 0; i < NUM_VOICES; i++) begin
        stamp_r[i] <= '0;
      end
`endif
    end else begin
      voice_restart <= '0;
      evt_dropped   <= 1'b0;
      case (state)
        IDLE: begin
          if (evt_valid) begin
            lat_on      <= evt_on;
            lat_key     <= evt_key;
            lat_period  <= evt_period;
            lat_duty    <= evt_duty;
            scan_idx    <= '0;
            match_found <= 1'b0;
            free_found  <= 1'b0;
`ifdef SQUARE_VOICE_STEAL_EN
            old_found   <= 1'b0;
`endif
            state       <= SCAN;
          end
        end
        SCAN: begin
          if (scan_hit && !match_found) begin
            match_found <= 1'b1;
            match_idx   <= scan_idx;
          end
          if (!scan_gate && !free_found) begin
            free_found <= 1'b1;
            free_idx   <= scan_idx;
          end
`ifdef SQUARE_VOICE_STEAL_EN
          // Strictly-greater compare keeps ties on the lower index.
          if (scan_gate && (!old_found || (scan_age > old_age))) begin
            old_found <= 1'b1;
            old_idx   <= scan_idx;
            old_age   <= scan_age;
          end
`endif
          if (scan_idx == LAST_IDX) begin
            state <= APPLY;
          end else begin
            scan_idx <= scan_idx + IDX_W'(1);
          end
        end
        APPLY: begin
          if (do_on) begin
            period_r[tgt_idx] <= lat_period;
            duty_r[tgt_idx]   <= duty_clip;
            key_r[tgt_idx]    <= lat_key;
`ifdef SQUARE_VOICE_STEAL_EN
            stamp_r[tgt_idx]  <= stamp_cnt;
            stamp_cnt         <= stamp_cnt + AGE_W'(1);
`endif
          end
          gate_r        <= gate_nxt;
          active_count  <= count_nxt;
          voice_restart <= restart_nxt;
          evt_dropped   <= drop;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_VOICES; i++) begin
      voice_period[16*i +: 16] = period_r[i];
      voice_duty[16*i +: 16]   = duty_r[i];
    end
  end

  assign voice_gate = gate_r;

endmodule

// File: tb/tb_square_voice_allocator.sv
// Self-checking bench for square_voice_allocator with a per-cycle voice-bank model.
// Honours SQUARE_VOICE_STEAL_EN the same way as the design build.
module tb_square_voice_allocator;
  localparam int NV = 4;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           evt_valid = 1'b0;
  logic           evt_on = 1'b0;
  logic [6:0]     evt_key = '0;
  logic [15:0]    evt_period = '0;
  logic [15:0]    evt_duty = '0;
  logic           evt_ready;
  logic [16*NV-1:0] voice_period;
  logic [16*NV-1:0] voice_duty;
  logic [NV-1:0]  voice_gate;
  logic [NV-1:0]  voice_restart;
  logic           evt_dropped;
  logic [4:0]     active_count;

  always #5 clk = ~clk;

  square_voice_allocator #(.NUM_VOICES(NV), .KEY_W(7), .AGE_W(8)) dut (
    .clk(clk), .reset(reset),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_on(evt_on),
    .evt_key(evt_key), .evt_period(evt_period), .evt_duty(evt_duty),
    .voice_period(voice_period), .voice_duty(voice_duty),
    .voice_gate(voice_gate), .voice_restart(voice_restart),
    .evt_dropped(evt_dropped), .active_count(active_count)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Voice-bank model: an accepted event takes effect NV+1 clock edges later.
  int      m_period [NV];
  int      m_duty   [NV];
  int      m_key    [NV];
  int      m_stamp  [NV];
  bit      m_gate   [NV];
  int      m_cnt = 0;
  bit      busy = 0;
  int      left = 0;
  bit      p_on;
  int      p_key, p_period, p_duty;
  bit [NV-1:0] m_restart = '0;
  bit      m_dropped = 0;

  task automatic model_clear();
    for (int i = 0; i < NV; i++) begin
      m_period[i] = 0; m_duty[i] = 0; m_key[i] = 0; m_stamp[i] = 0; m_gate[i] = 0;
    end
    m_cnt = 0; busy = 0; left = 0; m_restart = '0; m_dropped = 0;
  endtask

  task automatic model_apply();
    int t;
    t = -1;
    for (int i = 0; i < NV; i++)
      if (t < 0 && m_gate[i] && m_key[i] == p_key) t = i;
    if (!p_on) begin
      if (t < 0) m_dropped = 1;
      else m_gate[t] = 0;
    end else if (p_period == 0) begin
      m_dropped = 1;
    end else begin
      for (int i = 0; i < NV; i++)
        if (t < 0 && !m_gate[i]) t = i;
`ifdef SQUARE_VOICE_STEAL_EN
      if (t < 0) begin
        int best;
        best = -1;
        for (int i = 0; i < NV; i++) begin
          if (m_gate[i] && ((m_cnt - m_stamp[i] + 256) % 256) > best) begin
            best = (m_cnt - m_stamp[i] + 256) % 256;
            t = i;
          end
        end
      end
`endif
      if (t < 0) begin
        m_dropped = 1;
      end else begin
        m_period[t]  = p_period;
        m_duty[t]    = (p_duty > p_period) ? p_period : p_duty;
        m_key[t]     = p_key;
        m_gate[t]    = 1;
        m_stamp[t]   = m_cnt;
        m_cnt        = (m_cnt + 1) % 256;
        m_restart[t] = 1'b1;
      end
    end
  endtask

  initial begin
    model_clear();
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        model_clear();
      end else begin
        m_restart = '0;
        m_dropped = 0;
        if (busy) begin
          left--;
          if (left == 0) begin
            busy = 0;
            model_apply();
          end
        end else if (evt_valid) begin
          busy = 1; left = NV + 1;
          p_on = evt_on; p_key = int'(evt_key);
          p_period = int'(evt_period); p_duty = int'(evt_duty);
        end
      end
    end
  end

  initial begin
    logic [16*NV-1:0] e_per, e_dut;
    logic [NV-1:0]    e_gate;
    int               e_cnt;
    forever begin
      @(negedge clk);
      e_cnt = 0;
      for (int i = 0; i < NV; i++) begin
        e_per[16*i +: 16] = 16'(m_period[i]);
        e_dut[16*i +: 16] = 16'(m_duty[i]);
        e_gate[i] = m_gate[i];
        e_cnt += int'(m_gate[i]);
      end
      chk("evt_ready", evt_ready, (!busy && !reset));
      chk("voice_period", voice_period, e_per);
      chk("voice_duty", voice_duty, e_dut);
      chk("voice_gate", voice_gate, e_gate);
      chk("voice_restart", voice_restart, m_restart);
      chk("evt_dropped", evt_dropped, m_dropped);
      chk("active_count", active_count, e_cnt);
    end
  end

  task automatic send(input bit on, input int key, input int per, input int duty);
    int n;
    n = 0;
    @(negedge clk);
    evt_valid = 1'b1; evt_on = on; evt_key = 7'(key);
    evt_period = 16'(per); evt_duty = 16'(duty);
    while (!evt_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("accept_wait", evt_ready, 1'b1);
    @(posedge clk);
    #1 evt_valid = 1'b0;
  endtask

  // Observes the cycles after an accept: busy cycles, first restart pulse and dropped pulses.
  task automatic watch(output int rdy_low, output int rst_at, output int rst_cnt,
                       output logic [NV-1:0] rst_val, output int drop_cnt);
    rdy_low = 0; rst_at = 0; rst_cnt = 0; rst_val = '0; drop_cnt = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (!evt_ready) rdy_low++;
      if (|voice_restart) begin
        rst_cnt++;
        if (rst_at == 0) begin
          rst_at = k;
          rst_val = voice_restart;
        end
      end
      if (evt_dropped) drop_cnt++;
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    int rl, ra, rc, dc;
    logic [NV-1:0] rv;
    repeat (3) @(negedge clk);
    chk("reset_ready", evt_ready, 1'b0);
    chk("reset_count", active_count, 5'd0);
    chk("reset_gate", voice_gate, '0);
    #1 reset = 1'b0;

    send(1, 60, 100, 50);
    watch(rl, ra, rc, rv, dc);
    chk("t1_busy_cycles", rl, 5);
    chk("t1_restart_at", ra, 6);
    chk("t1_restart_cnt", rc, 1);
    chk("t1_restart_val", rv, 4'b0001);
    chk("t1_period0", voice_period[15:0], 16'd100);
    chk("t1_duty0", voice_duty[15:0], 16'd50);
    chk("t1_count", active_count, 5'd1);

    send(1, 60, 200, 50);
    watch(rl, ra, rc, rv, dc);
    chk("retrig_period0", voice_period[15:0], 16'd200);
    chk("retrig_gate", voice_gate, 4'b0001);
    chk("retrig_restart", rv, 4'b0001);

    send(1, 62, 120, 60);
    watch(rl, ra, rc, rv, dc);
    chk("on62_gate", voice_gate, 4'b0011);
    send(0, 62, 0, 0);
    watch(rl, ra, rc, rv, dc);
    chk("off62_gate", voice_gate, 4'b0001);
    chk("off62_period1", voice_period[31:16], 16'd120);
    chk("off62_no_restart", rc, 0);
    chk("off62_count", active_count, 5'd1);
    send(0, 70, 0, 0);
    watch(rl, ra, rc, rv, dc);
    chk("off70_dropped", dc, 1);

    send(1, 10, 100, 300);
    watch(rl, ra, rc, rv, dc);
    chk("clip_duty1", voice_duty[31:16], 16'd100);
    send(1, 11, 0, 5);
    watch(rl, ra, rc, rv, dc);
    chk("per0_dropped", dc, 1);
    chk("per0_no_restart", rc, 0);
    chk("per0_gate", voice_gate, 4'b0011);

    pulse_reset();
    send(1, 60, 100, 50); watch(rl, ra, rc, rv, dc);
    send(1, 62, 110, 50); watch(rl, ra, rc, rv, dc);
    send(1, 64, 120, 50); watch(rl, ra, rc, rv, dc);
    send(1, 65, 130, 50); watch(rl, ra, rc, rv, dc);
    chk("full_count", active_count, 5'd4);
    send(1, 67, 80, 40);
    watch(rl, ra, rc, rv, dc);
`ifdef SQUARE_VOICE_STEAL_EN
    chk("steal_period0", voice_period[15:0], 16'd80);
    chk("steal_restart", rv, 4'b0001);
    chk("steal_dropped", dc, 0);
`else
    chk("nosteal_period0", voice_period[15:0], 16'd100);
    chk("nosteal_dropped", dc, 1);
    chk("nosteal_restart", rc, 0);
`endif
    chk("steal_count", active_count, 5'd4);

    send(1, 70, 50, 25);
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    chk("abort_gate", voice_gate, '0);
    chk("abort_period", voice_period, '0);
    chk("abort_count", active_count, 5'd0);
    chk("abort_ready", evt_ready, 1'b0);
    @(negedge clk);
    #1 reset = 1'b0;
    #1 chk("post_reset_ready", evt_ready, 1'b1);
    send(1, 70, 50, 25);
    watch(rl, ra, rc, rv, dc);
    chk("post_reset_period0", voice_period[15:0], 16'd50);
    chk("post_reset_gate", voice_gate, 4'b0001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
